// File: rtl/amp_shaper_pkg.sv
// Shared definitions for the polyphonic amplitude shaper.
// Holds the per-voice envelope state encoding and the fixed scale applied
// to the sustain fraction.
package amp_shaper_pkg;

  localparam int unsigned StateBits = 3;
  // The sustain input is a fraction of peak in 1/256 steps.
  localparam int unsigned SusShift  = 8;

  typedef enum logic [StateBits-1:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } env_state_e;

endpackage

// File: rtl/env_step.sv
// Combinational ADSR step for one voice.
// Given the current voice registers and the shared envelope controls, it
// produces the state and envelope the voice holds after one sample update.
//   state_i/env_i        current voice state and envelope (Q0.ENV_BITS)
//   peak_i/sus_i         stored attack target and sustain level
//   attack_step_i        linear attack increment
//   decay_shift_i        exponential decay time constant
//   release_shift_i      exponential release time constant
//   state_o/env_o        next state and envelope
module env_step
  import amp_shaper_pkg::*;
#(
  parameter int unsigned ENV_BITS = 16
) (
  input  env_state_e          state_i,
  input  logic [ENV_BITS-1:0] env_i,
  input  logic [ENV_BITS-1:0] peak_i,
  input  logic [ENV_BITS-1:0] sus_i,
  input  logic [ENV_BITS-1:0] attack_step_i,
  input  logic [4:0]          decay_shift_i,
  input  logic [4:0]          release_shift_i,
  output env_state_e          state_o,
  output logic [ENV_BITS-1:0] env_o
);

  // One extra bit so the attack sum cannot wrap before the peak clamp.
  logic [ENV_BITS:0]   att_sum;
  logic [ENV_BITS-1:0] dec_diff;
  logic [ENV_BITS-1:0] dec_step;
  logic [ENV_BITS-1:0] dec_next;
  logic [ENV_BITS-1:0] rel_step;

  always_comb begin
    att_sum  = {1'b0, env_i} + {1'b0, attack_step_i};
    dec_diff = (env_i > sus_i) ? (env_i - sus_i) : '0;
    dec_step = dec_diff >> decay_shift_i;
    // A minimum step of one keeps the exponential tails from stalling.
    if (dec_step == '0) begin
      dec_step = ENV_BITS'(1);
    end
    dec_next = env_i - dec_step;
    rel_step = env_i >> release_shift_i;
    if (rel_step == '0) begin
      rel_step = ENV_BITS'(1);
    end

    state_o = state_i;
    env_o   = env_i;
    case (state_i)
      StAttack: begin
        if (att_sum >= {1'b0, peak_i}) begin
          env_o   = peak_i;
          state_o = StDecay;
        end else begin
          env_o = att_sum[ENV_BITS-1:0];
        end
      end
      StDecay: begin
        if ((env_i <= sus_i) || (dec_next <= sus_i)) begin
          env_o   = sus_i;
          state_o = StSustain;
        end else begin
          env_o = dec_next;
        end
      end
      StSustain: begin
        env_o = env_i;
      end
      StRelease: begin
        if (env_i <= rel_step) begin
          env_o   = '0;
          state_o = StIdle;
        end else begin
          env_o = env_i - rel_step;
        end
      end
      default: begin
        env_o   = '0;
        state_o = StIdle;
      end
    endcase
  end

endmodule

// File: rtl/poly_amp_shaper.sv
// Time-multiplexed polyphonic amplitude shaper.
// Keeps an ADSR envelope per voice, advances a voice's envelope once per
// sample of that voice, and scales the sample by the pre-update envelope.
//   note_on/note_off/note_voice/velocity   note strobes from the allocator
//   attack_step/decay_shift/sustain/release_shift   shared envelope controls
//   s_valid/s_voice/s_data                 tagged input samples
//   m_valid/m_voice/m_data                 shaped samples, 2 cycles later
//   voice_active                           per-voice not-idle flags
//   free_voice/free_valid                  lowest idle voice for allocation
module poly_amp_shaper
  import amp_shaper_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned WORD_BITS  = 18,
  parameter int unsigned ENV_BITS   = 16,
  parameter int unsigned VEL_BITS   = 7,
  parameter int unsigned VIDX_BITS  = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  note_on,
  input  logic                  note_off,
  input  logic [VIDX_BITS-1:0]  note_voice,
  input  logic [VEL_BITS-1:0]   velocity,
  input  logic [ENV_BITS-1:0]   attack_step,
  input  logic [4:0]            decay_shift,
  input  logic [7:0]            sustain,
  input  logic [4:0]            release_shift,
  input  logic                  s_valid,
  input  logic [VIDX_BITS-1:0]  s_voice,
  input  logic [WORD_BITS-1:0]  s_data,
  output logic                  m_valid,
  output logic [VIDX_BITS-1:0]  m_voice,
  output logic [WORD_BITS-1:0]  m_data,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [VIDX_BITS-1:0]  free_voice,
  output logic                  free_valid
);

  env_state_e          state_q [NUM_VOICES];
  env_state_e          state_d [NUM_VOICES];
  logic [ENV_BITS-1:0] env_q   [NUM_VOICES];
  logic [ENV_BITS-1:0] env_d   [NUM_VOICES];
  logic [ENV_BITS-1:0] peak_q  [NUM_VOICES];
  logic [ENV_BITS-1:0] peak_d  [NUM_VOICES];
  logic [ENV_BITS-1:0] sus_q   [NUM_VOICES];
  logic [ENV_BITS-1:0] sus_d   [NUM_VOICES];

  logic                  note_start;
  logic                  note_stop;
  logic [ENV_BITS-1:0]   peak_new;
  logic [ENV_BITS+7:0]   sus_prod;
  logic [ENV_BITS-1:0]   sus_new;
  env_state_e            step_state;
  logic [ENV_BITS-1:0]   step_env;
  logic [ENV_BITS-1:0]   rd_env;

  logic                       s1_valid_q;
  logic [VIDX_BITS-1:0]       s1_voice_q;
  logic signed [WORD_BITS-1:0] s1_data_q;
  logic [ENV_BITS-1:0]        s1_env_q;

  logic signed [WORD_BITS+ENV_BITS:0] prod;
  logic signed [WORD_BITS+ENV_BITS:0] rnd;
  logic [WORD_BITS-1:0]               m_data_d;

  // Zero velocity is the MIDI convention for a note-off.
  assign note_start = note_on && (velocity != '0);
  assign note_stop  = note_off || (note_on && (velocity == '0));
  assign peak_new   = {velocity, {(ENV_BITS - VEL_BITS){1'b1}}};
  assign sus_prod   = peak_new * sustain;
  assign sus_new    = ENV_BITS'(sus_prod >> SusShift);

  env_step #(
    .ENV_BITS (ENV_BITS)
  ) u_env_step (
    .state_i         (state_q[s_voice]),
    .env_i           (env_q[s_voice]),
    .peak_i          (peak_q[s_voice]),
    .sus_i           (sus_q[s_voice]),
    .attack_step_i   (attack_step),
    .decay_shift_i   (decay_shift),
    .release_shift_i (release_shift),
    .state_o         (step_state),
    .env_o           (step_env)
  );

  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      state_d[v] = state_q[v];
      env_d[v]   = env_q[v];
      peak_d[v]  = peak_q[v];
      sus_d[v]   = sus_q[v];
    end
    // A note strobe on the sampled voice replaces that cycle's envelope step.
    if (s_valid && !((note_start || note_stop) && (s_voice == note_voice))) begin
      state_d[s_voice] = step_state;
      env_d[s_voice]   = step_env;
    end
    // Retrigger keeps env so the attack ramps from the present level.
    if (note_start) begin
      state_d[note_voice] = StAttack;
      peak_d[note_voice]  = peak_new;
      sus_d[note_voice]   = sus_new;
    end else if (note_stop && (state_q[note_voice] inside {StAttack, StDecay, StSustain})) begin
      state_d[note_voice] = StRelease;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= StIdle;
        env_q[v]   <= '0;
        peak_q[v]  <= '0;
        sus_q[v]   <= '0;
      end
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      peak_q  <= peak_d;
      sus_q   <= sus_d;
    end
  end

  // Stage 1: capture the sample with the pre-update envelope.
  assign rd_env = (state_q[s_voice] == StIdle) ? '0 : env_q[s_voice];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_voice_q <= '0;
      s1_data_q  <= '0;
      s1_env_q   <= '0;
    end else begin
      s1_valid_q <= s_valid;
      s1_voice_q <= s_voice;
      s1_data_q  <= s_data;
      s1_env_q   <= rd_env;
    end
  end

  // Stage 2: signed x unsigned product, round half up, drop the fraction.
  always_comb begin
    prod     = s1_data_q * $signed({1'b0, s1_env_q});
    rnd      = prod + $signed({{(WORD_BITS + 1){1'b0}}, 1'b1, {(ENV_BITS - 1){1'b0}}});
    m_data_d = WORD_BITS'(rnd >>> ENV_BITS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_voice <= '0;
      m_data  <= '0;
    end else begin
      m_valid <= s1_valid_q;
      m_voice <= s1_voice_q;
      m_data  <= m_data_d;
    end
  end

  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      voice_active[v] = (state_q[v] != StIdle);
    end
  end

  // Scan from the top so the lowest idle index is the last one written.
  always_comb begin
    free_voice = '0;
    free_valid = 1'b0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_active[v]) begin
        free_voice = VIDX_BITS'(v);
        free_valid = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_poly_amp_shaper.sv
module tb_poly_amp_shaper;

  localparam int NV = 8;
  localparam int WB = 18;
  localparam int EB = 16;
  localparam int VB = 7;
  localparam int IB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          note_on = 1'b0;
  logic          note_off = 1'b0;
  logic [IB-1:0] note_voice = '0;
  logic [VB-1:0] velocity = '0;
  logic [EB-1:0] attack_step = '0;
  logic [4:0]    decay_shift = '0;
  logic [7:0]    sustain = '0;
  logic [4:0]    release_shift = '0;
  logic          s_valid = 1'b0;
  logic [IB-1:0] s_voice = '0;
  logic [WB-1:0] s_data = '0;
  logic          m_valid;
  logic [IB-1:0] m_voice;
  logic [WB-1:0] m_data;
  logic [NV-1:0] voice_active;
  logic [IB-1:0] free_voice;
  logic          free_valid;

  always #5 clk = ~clk;

  poly_amp_shaper #(
    .NUM_VOICES (NV),
    .WORD_BITS  (WB),
    .ENV_BITS   (EB),
    .VEL_BITS   (VB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .note_on       (note_on),
    .note_off      (note_off),
    .note_voice    (note_voice),
    .velocity      (velocity),
    .attack_step   (attack_step),
    .decay_shift   (decay_shift),
    .sustain       (sustain),
    .release_shift (release_shift),
    .s_valid       (s_valid),
    .s_voice       (s_voice),
    .s_data        (s_data),
    .m_valid       (m_valid),
    .m_voice       (m_voice),
    .m_data        (m_data),
    .voice_active  (voice_active),
    .free_voice    (free_voice),
    .free_valid    (free_valid)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: states 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  int            mst  [NV];
  int            menv [NV];
  int            mpk  [NV];
  int            msus [NV];
  bit            st1_v, exp_v;
  int            st1_voice, exp_voice;
  logic [WB-1:0] st1_data, exp_data;
  bit            m_on, m_off;
  int            m_sv, m_nv;
  longint        m_e, m_p;

  function automatic void mstep(int v);
    int d;
    int st;
    case (mst[v])
      1: begin
        menv[v] = menv[v] + int'(attack_step);
        if (menv[v] >= mpk[v]) begin
          menv[v] = mpk[v];
          mst[v]  = 2;
        end
      end
      2: begin
        d  = (menv[v] > msus[v]) ? menv[v] - msus[v] : 0;
        st = d >> decay_shift;
        if (st < 1) st = 1;
        if (menv[v] - st <= msus[v]) begin
          menv[v] = msus[v];
          mst[v]  = 3;
        end else begin
          menv[v] = menv[v] - st;
        end
      end
      4: begin
        st = menv[v] >> release_shift;
        if (st < 1) st = 1;
        menv[v] = menv[v] - st;
        if (menv[v] <= 0) begin
          menv[v] = 0;
          mst[v]  = 0;
        end
      end
      0: menv[v] = 0;
      default: ;
    endcase
  endfunction

  function automatic logic [NV-1:0] m_active();
    logic [NV-1:0] a;
    for (int v = 0; v < NV; v++) a[v] = (mst[v] != 0);
    return a;
  endfunction

  function automatic int m_free();
    for (int v = 0; v < NV; v++) if (mst[v] == 0) return v;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NV; v++) begin
        mst[v] = 0; menv[v] = 0; mpk[v] = 0; msus[v] = 0;
      end
      st1_v = 1'b0; exp_v = 1'b0; st1_voice = 0; exp_voice = 0;
      st1_data = '0; exp_data = '0;
    end else begin
      exp_v = st1_v; exp_voice = st1_voice; exp_data = st1_data;
      st1_v = s_valid;
      m_sv  = int'(s_voice);
      m_nv  = int'(note_voice);
      if (s_valid) begin
        m_e = (mst[m_sv] == 0) ? 0 : menv[m_sv];
        m_p = longint'($signed(s_data)) * m_e;
        m_p = (m_p + 32768) >>> 16;
        st1_voice = m_sv;
        st1_data  = m_p[WB-1:0];
      end
      m_on  = note_on && (velocity != 0);
      m_off = note_off || (note_on && (velocity == 0));
      if (s_valid && !((m_on || m_off) && m_sv == m_nv)) mstep(m_sv);
      if (m_on) begin
        mpk[m_nv]  = (int'(velocity) << (EB - VB)) | ((1 << (EB - VB)) - 1);
        msus[m_nv] = (mpk[m_nv] * int'(sustain)) >> 8;
        mst[m_nv]  = 1;
      end else if (m_off && mst[m_nv] >= 1 && mst[m_nv] <= 3) begin
        mst[m_nv] = 4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", m_valid, exp_v);
      if (exp_v) begin
        chk("m_voice", m_voice, exp_voice);
        chk("m_data", m_data, exp_data);
      end
      chk("voice_active", voice_active, m_active());
      chk("free_valid", free_valid, m_active() != 8'hFF);
      chk("free_voice", free_voice, m_free());
    end
  end

  task automatic drive(bit on, bit off, int nv, int vel, bit sv, int vo, int d);
    note_on    = on;
    note_off   = off;
    note_voice = IB'(nv);
    velocity   = VB'(vel);
    s_valid    = sv;
    s_voice    = IB'(vo);
    s_data     = WB'(d);
    @(posedge clk);
    #1;
    note_on  = 1'b0;
    note_off = 1'b0;
    s_valid  = 1'b0;
  endtask

  task automatic sample_chk(int vo, int d, int exp, string name);
    drive(0, 0, 0, 0, 1, vo, d);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, m_valid, 1);
    chk(name, $signed(m_data), exp);
  endtask

  initial begin
    int rel[16];
    int vo, d;
    rel = '{'h7FFF, 'h4000, 'h2000, 'h1000, 'h0800, 'h0400, 'h0200, 'h0100,
            'h0080, 'h0040, 'h0020, 'h0010, 'h0008, 'h0004, 'h0002, 'h0001};
    attack_step   = 16'h4000;
    decay_shift   = 5'd0;
    sustain       = 8'h80;
    release_shift = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_active", voice_active, 0);
    chk("rst_free_valid", free_valid, 1);
    chk("rst_free_voice", free_voice, 0);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Attack from zero, then decay straight to sustain.
    drive(1, 0, 3, 127, 0, 0, 0);
    chk("on_active", voice_active, 8'h08);
    sample_chk(3, 'h10000, 'h0000, "att0");
    sample_chk(3, 'h10000, 'h4000, "att1");
    sample_chk(3, 'h10000, 'h8000, "att2");
    sample_chk(3, 'h10000, 'hC000, "att3");
    chk("model_att_to_decay", mst[3], 2);
    sample_chk(3, 'h10000, 'hFFFF, "att_peak");
    chk("model_sus_state", mst[3], 3);
    chk("model_sus_env", menv[3], 'h7FFF);

    // Sustain holds; a sustain input change must not reach the stored level.
    sustain = 8'h20;
    for (int i = 0; i < 100; i++) drive(0, 0, 0, 0, 1, 3, 'h10000);
    sample_chk(3, 'h10000, 'h7FFF, "sus_hold");
    sustain = 8'h80;

    // Release at shift 1 down to idle.
    drive(0, 1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      sample_chk(3, 'h10000, rel[i], "rel");
      if (i == 14) chk("rel_active_15", voice_active[3], 1);
    end
    chk("rel_idle", voice_active[3], 0);
    sample_chk(3, 'h10000, 0, "idle_out");

    // Retrigger during release, colliding with a sample of the same voice.
    drive(1, 0, 3, 127, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 3, 'h10000);
    drive(0, 1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 1, 3, 'h10000);
    chk("model_rel_2000", menv[3], 'h2000);
    drive(1, 0, 3, 127, 1, 3, 'h10000);
    @(posedge clk);
    #1;
    chk("coll_valid", m_valid, 1);
    chk("coll_out", $signed(m_data), 'h2000);
    chk("model_coll_state", mst[3], 1);
    sample_chk(3, 'h10000, 'h2000, "retrig_pre");
    chk("model_retrig_env", menv[3], 'h6000);
    sample_chk(3, 'h10000, 'h6000, "retrig_post");

    // Allocation: fill every voice, then free voice 5.
    for (int v = 0; v < NV; v++) drive(1, 0, v, 127, 0, 0, 0);
    chk("alloc_full_valid", free_valid, 0);
    chk("alloc_full_voice", free_voice, 0);
    drive(0, 0, 0, 0, 1, 5, 'h10000);
    drive(0, 0, 0, 0, 1, 5, 'h10000);
    drive(0, 1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 1, 5, 'h10000);
    @(posedge clk);
    #1;
    chk("alloc_free_voice", free_voice, 5);
    chk("alloc_free_valid", free_valid, 1);
    drive(0, 0, 0, 0, 1, 6, 'h10000);
    drive(0, 0, 0, 0, 1, 6, 'h10000);
    sample_chk(6, -65536, -32768, "neg");

    // Interleaved stream with note events and control changes.
    decay_shift = 5'd3;
    attack_step = 16'h1800;
    sustain     = 8'h40;
    for (int i = 0; i < 48; i++) begin
      vo = (i * 5) % NV;
      d  = (i % 2 == 1) ? -(i * 1000) : i * 1237;
      if (i == 10)      drive(0, 1, 2, 0, 1, vo, d);
      else if (i == 20) drive(1, 0, 4, 40, 1, vo, d);
      else if (i == 30) drive(0, 1, 6, 0, 1, vo, d);
      else if (i == 40) drive(1, 0, 1, 0, 1, vo, d);
      else              drive(0, 0, 0, 0, 1, vo, d);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset with samples in flight.
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 7, 'h8000);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_m_voice", m_voice, 0);
    chk("mid_rst_active", voice_active, 0);
    chk("mid_rst_free_valid", free_valid, 1);
    chk("mid_rst_free_voice", free_voice, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_quiet", m_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
